// File: rtl/divider_shift_sub_pkg.sv
// divider_pkg: shared state encoding and default widths for the shift-subtract divider
package divider_pkg;
  localparam int L_state = 3;
  localparam int L_divn_def = 8;
  localparam int L_divr_def = 4;
  typedef enum logic [L_state-1:0] {
    S_idle = 3'd0,
    S_run  = 3'd1,
    S_fix  = 3'd2,
    S_done = 3'd3,
    S_err  = 3'd4
  } state_t;
endpackage

// File: rtl/divider_shift_sub_if.sv
// divider_shift_sub_if: Start/Ready command and result bundle between controller and divider
interface divider_shift_sub_if
  import divider_pkg::*;
#(
  parameter int L_divn = L_divn_def,
  parameter int L_divr = L_divr_def
);
  logic              Start;
  logic              signed_mode;
  logic [L_divn-1:0] word1;
  logic [L_divr-1:0] word2;
  logic [L_divn-1:0] quotient;
  logic [L_divr-1:0] remainder;
  logic              Ready;
  logic              Error;
  logic              Overflow;
  modport master (
    output Start, signed_mode, word1, word2,
    input  quotient, remainder, Ready, Error, Overflow
  );
  modport slave (
    input  Start, signed_mode, word1, word2,
    output quotient, remainder, Ready, Error, Overflow
  );
endinterface

// File: rtl/divider_shift_sub_div_step.sv
// div_step: one restoring-division iteration producing the new partial remainder and quotient bit
module div_step #(
  parameter int L_divr = 4
) (
  input  logic [L_divr:0]   prem_i,
  input  logic              bit_i,
  input  logic [L_divr-1:0] divisor_i,
  output logic [L_divr:0]   prem_o,
  output logic              q_o
);
  logic [L_divr+1:0] sh;
  logic [L_divr+1:0] trial;
  // prem stays below the divisor, so the shifted value never reaches the sign bit of trial
  assign sh     = {prem_i, bit_i};
  assign trial  = sh - {2'b00, divisor_i};
  assign q_o    = ~trial[L_divr+1];
  assign prem_o = q_o ? trial[L_divr:0] : sh[L_divr:0];
endmodule

// File: rtl/divider_shift_sub.sv
// divider_shift_sub: radix-2 shift-and-subtract divider, one quotient bit per clock, signed/unsigned
module divider_shift_sub
  import divider_pkg::*;
#(
  parameter int L_divn = L_divn_def,
  parameter int L_divr = L_divr_def
) (
  input logic clock,
  input logic reset,
  divider_shift_sub_if.slave bus
);
  localparam int L_cnt = $clog2(L_divn);
  state_t            state_q, state_d;
  logic [L_divn-1:0] dvd_q, dvd_d, quo_q, quo_d, mag1, q_fix;
  logic [L_divr-1:0] dvr_q, dvr_d, rem_q, rem_d, mag2, r_fix;
  logic [L_divr:0]   prem_q, prem_d, prem_nx;
  logic [L_cnt-1:0]  cnt_q, cnt_d;
  logic              q_neg_q, q_neg_d, r_neg_q, r_neg_d, sm_q, sm_d;
  logic              err_q, err_d, ovf_q, ovf_d;
  logic              idle, accept, q_bit, s1, s2, zero_div;
  div_step #(.L_divr(L_divr)) u_step (
    .prem_i    (prem_q),
    .bit_i     (dvd_q[L_divn-1]),
    .divisor_i (dvr_q),
    .prem_o    (prem_nx),
    .q_o       (q_bit)
  );
  assign idle     = (state_q == S_idle) || (state_q == S_done) || (state_q == S_err);
  assign accept   = idle && bus.Start;
  assign zero_div = (bus.word2 == '0);
  assign s1       = bus.signed_mode & bus.word1[L_divn-1];
  assign s2       = bus.signed_mode & bus.word2[L_divr-1];
  assign mag1     = s1 ? -bus.word1 : bus.word1;
  assign mag2     = s2 ? -bus.word2 : bus.word2;
  assign q_fix    = q_neg_q ? -dvd_q : dvd_q;
  assign r_fix    = r_neg_q ? -prem_q[L_divr-1:0] : prem_q[L_divr-1:0];
  assign bus.Ready     = idle && reset;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.Error     = err_q;
  assign bus.Overflow  = ovf_q;
  // next-state: accept commands when idle, iterate in S_run, apply signs in S_fix
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvr_d   = dvr_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    sm_d    = sm_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_run: begin
        dvd_d   = {dvd_q[L_divn-2:0], q_bit};
        prem_d  = prem_nx;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == L_cnt'(L_divn - 1)) ? S_fix : S_run;
      end
      S_fix: begin
        quo_d   = q_fix;
        rem_d   = r_fix;
        ovf_d   = sm_q & ~q_neg_q & dvd_q[L_divn-1];
        state_d = S_done;
      end
      default: begin
        if (accept) begin
          state_d = zero_div ? S_err : S_run;
          err_d   = zero_div;
          ovf_d   = 1'b0;
          if (!zero_div) begin
            dvd_d   = mag1;
            dvr_d   = mag2;
            q_neg_d = s1 ^ s2;
            r_neg_d = s1;
            sm_d    = bus.signed_mode;
            prem_d  = '0;
            cnt_d   = '0;
          end
        end
      end
    endcase
  end
  // state and datapath registers, cleared asynchronously so a reset abandons any run
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_idle;
      dvd_q   <= '0;
      dvr_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      sm_q    <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvr_q   <= dvr_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      sm_q    <= sm_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_divider_shift_sub.sv
// tb_divider_shift_sub: scoreboard bench for the shift-subtract divider
module tb_divider_shift_sub;
  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       err;
    logic       ovf;
  } exp_t;
  logic clk;
  logic rst_n;
  exp_t sb[$];
  logic [7:0] last_q;
  logic [3:0] last_r;
  int n_cmp;
  int n_err;
  divider_shift_sub_if #(.L_divn(8), .L_divr(4)) bus ();
  divider_shift_sub #(.L_divn(8), .L_divr(4)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic exp_t obs();
    return {bus.quotient, bus.remainder, bus.Error, bus.Overflow};
  endfunction
  task automatic push_exp(input logic [7:0] w1, input logic [3:0] w2, input logic sm);
    exp_t e;
    int a, b, q, r;
    a = sm ? int'($signed(w1)) : int'(w1);
    b = sm ? int'($signed(w2)) : int'(w2);
    if (b == 0) begin
      e = {last_q, last_r, 1'b1, 1'b0};
    end else begin
      q = a / b;
      r = a % b;
      e.q = q[7:0];
      e.r = r[3:0];
      e.err = 1'b0;
      e.ovf = sm && (q > 127);
      last_q = e.q;
      last_r = e.r;
    end
    sb.push_back(e);
  endtask
  task automatic drive(input logic [7:0] w1, input logic [3:0] w2, input logic sm);
    bus.Start = 1'b1;
    bus.word1 = w1;
    bus.word2 = w2;
    bus.signed_mode = sm;
    push_exp(w1, w2, sm);
  endtask
  task automatic do_cmd(input logic [7:0] w1, input logic [3:0] w2, input logic sm, output int lat);
    drive(w1, w2, sm);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    bus.Start = 1'b0;
    while (!bus.Ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: Ready still %b after %0d cycles, want 1", bus.Ready, lat);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b1;
    bus.Start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.word1 = '0;
    bus.word2 = '0;
    last_q = '0;
    last_r = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.Ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", bus.Ready); end
    n_cmp++;
    if (obs() !== exp_t'(0)) begin n_err++; $display("FAIL reset_outputs: got %h want 0", obs()); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.Ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", bus.Ready); end
  endtask
  task automatic test_unsigned();
    int lat;
    exp_t e;
    do_cmd(8'd200, 4'd7, 1'b0, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== 9) begin n_err++; $display("FAIL unsigned_latency: got %0d want 9", lat); end
    n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL unsigned_200_7: got %h want %h", obs(), e); end
    n_cmp++;
    if ({bus.quotient, bus.remainder} !== {8'd28, 4'd4}) begin
      n_err++; $display("FAIL unsigned_200_7_const: got q=%0d r=%0d want 28 4", bus.quotient, bus.remainder);
    end
  endtask
  task automatic test_signed();
    int lat;
    exp_t e;
    do_cmd(8'h9C, 4'h7, 1'b1, lat);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e || {bus.quotient, bus.remainder} !== {8'hF2, 4'hE}) begin
      n_err++; $display("FAIL signed_m100_7: got %h want %h", obs(), e);
    end
    do_cmd(8'h80, 4'hF, 1'b1, lat);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e || bus.Overflow !== 1'b1 || bus.quotient !== 8'h80) begin
      n_err++; $display("FAIL signed_overflow: got %h want %h", obs(), e);
    end
    do_cmd(8'd9, 4'd3, 1'b0, lat);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e || bus.Overflow !== 1'b0) begin
      n_err++; $display("FAIL overflow_clear: got %h want %h", obs(), e);
    end
  endtask
  task automatic test_div_zero();
    int lat;
    exp_t e;
    do_cmd(8'd55, 4'd0, 1'b0, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== 0) begin n_err++; $display("FAIL divzero_ready: got latency %0d want 0", lat); end
    n_cmp++;
    if (obs() !== e || bus.Error !== 1'b1 || bus.quotient !== 8'd3) begin
      n_err++; $display("FAIL divzero_hold: got %h want %h", obs(), e);
    end
    do_cmd(8'd0, 4'd5, 1'b0, lat);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e || bus.Error !== 1'b0) begin
      n_err++; $display("FAIL divzero_clear: got %h want %h", obs(), e);
    end
  endtask
  task automatic test_mid_run();
    int lat;
    exp_t e;
    drive(8'd100, 4'd9, 1'b0);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    bus.Start = 1'b0;
    while (!bus.Ready && lat < 40) begin
      @(negedge clk);
      lat++;
      bus.Start = (lat == 2);
      bus.word1 = 8'd250;
      bus.word2 = 4'd3;
    end
    bus.Start = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (lat !== 9) begin n_err++; $display("FAIL repulse_latency: got %0d want 9", lat); end
    n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL repulse_result: got %h want %h", obs(), e); end
    drive(8'd77, 4'd5, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.Ready !== 1'b0 || obs() !== exp_t'(0)) begin
      n_err++; $display("FAIL midrun_reset: got ready=%b out=%h want ready=0 out=0", bus.Ready, obs());
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.Ready !== 1'b0) begin n_err++; $display("FAIL reset_hold_ready: got %b want 0", bus.Ready); end
    rst_n = 1'b1;
    void'(sb.pop_back());
    last_q = '0;
    last_r = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.Ready !== 1'b1 || obs() !== exp_t'(0)) begin
      n_err++; $display("FAIL after_reset: got ready=%b out=%h want ready=1 out=0", bus.Ready, obs());
    end
  endtask
  task automatic test_back_to_back();
    int total, idx, gap, maxgap, k;
    exp_t e;
    logic [7:0] w1;
    logic [3:0] w2;
    total = 2 * 256 * 15;
    w1 = 8'd0;
    w2 = 4'd1;
    drive(w1, w2, 1'b0);
    idx = 1;
    gap = 0;
    maxgap = 0;
    while (idx <= total) begin
      @(negedge clk);
      gap++;
      if (gap > 50) begin
        n_cmp++;
        n_err++;
        $display("FAIL sweep_timeout: Ready still %b after %0d cycles at op %0d", bus.Ready, gap, idx);
        break;
      end
      if (bus.Ready) begin
        e = sb.pop_front();
        n_cmp++;
        if (obs() !== e) begin
          n_err++; $display("FAIL sweep_op%0d: got %h want %h", idx - 1, obs(), e);
        end
        if (gap > maxgap) maxgap = gap;
        gap = 0;
        if (idx < total) begin
          k = idx % 3840;
          w1 = 8'(k / 15);
          w2 = 4'(k % 15 + 1);
          drive(w1, w2, idx >= 3840);
        end else begin
          bus.Start = 1'b0;
        end
        idx++;
      end
    end
    bus.Start = 1'b0;
    n_cmp++;
    if (maxgap !== 10) begin n_err++; $display("FAIL sweep_gap: got %0d cycles per op want 10", maxgap); end
  endtask
  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
